vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
Shares one single-port frame-buffer RAM (160x120 pixels, 8-bit RRRGGGBB) between two masters: the VGA scan-out line-buffer fill and a CPU write port. Video fill has absolute priority. CPU writes are granted only in cycles the fill does not need. The block sits between the frame buffer RAM, a double-banked line buffer read by the VGA pixel pipeline, and the CPU/bus side, all in the 25 MHz pixel clock domain.

Parameters:
H_PIX, 160, frame-buffer pixels per row (words per fill burst)
V_PIX, 120, frame-buffer rows
AW, 15, RAM address width (must satisfy 2^AW >= H_PIX*V_PIX)
DW, 8, pixel data width

Ports:
clk  in  1  pixel clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
line_req  in  1  one-cycle pulse from VGA timing: start filling fb row line_row
line_row  in  7  fb row index, 0..V_PIX-1, sampled on line_req
cpu_valid  in  1  CPU write request
cpu_ready  out  1  CPU write accepted this cycle (valid&&ready)
cpu_addr  in  AW  CPU pixel address, linear row*H_PIX+col
cpu_data  in  DW  CPU pixel data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data, valid 1 cycle after a read (ram_en && !ram_we)
lb_we  out  1  line-buffer write strobe
lb_bank  out  1  line-buffer bank being filled, toggles at each fill start
lb_addr  out  8  line-buffer column, 0..H_PIX-1
lb_wdata  out  DW  line-buffer data
fill_busy  out  1  fill burst in progress
overrun  out  1  sticky: line_req arrived while a fill was in progress

Behaviour:
- Reset: all outputs 0; lb_bank=0; state IDLE. An assertion of rst_n mid-burst aborts the burst immediately. No RAM write completes after reset asserts.
- States: IDLE, FILL, DRAIN.
- IDLE, on line_req: latch row_base = line_row*H_PIX. Compute it with shift-add (128+32), not a multiplier. Toggle lb_bank, clear the column counter, go to FILL. The same cycle issues no CPU grant.
- IDLE, no line_req: cpu_ready = cpu_valid. On a handshake, ram_en=1, ram_we=1, ram_addr=cpu_addr, ram_wdata=cpu_data in the same cycle (combinational grant, registered RAM drive not required).
- FILL: one read per cycle. ram_en=1, ram_we=0, ram_addr=row_base+col, col increments 0..H_PIX-1. cpu_ready=0. After col=H_PIX-1 is issued, go to DRAIN.
- DRAIN: one cycle for the last read data. cpu_ready may assert. Return to IDLE.
- Line-buffer write path is a registered copy of the read request. lb_we/lb_addr are the FILL read strobe/col delayed 1 cycle, and lb_wdata=ram_rdata. The first lb_we comes 2 cycles after line_req. The burst occupies exactly H_PIX+1 cycles after the line_req cycle.
- fill_busy=1 from the cycle after line_req through DRAIN inclusive.
- line_req while in FILL or DRAIN: set overrun (cleared only by reset). Restart the fill with the new row from col 0 and toggle lb_bank again. The pending lb write of the aborted burst still completes.
- line_req with line_row >= V_PIX: the fill proceeds with row_base computed unmodified. No clamping; the address wraps modulo 2^AW.
- CPU address out of range (>= H_PIX*V_PIX): the write is still accepted and driven. Range checking is the bus side's job.
- cpu_valid may be held across FILL. The request stays pending, with no data loss, until cpu_ready.
- CPU and fill never drive the RAM in the same cycle.

Decomposition:
- Shared package vga_pkg: H_PIX, V_PIX, AW, DW, pixel field slices (R=[7:5], G=[4:2], B=[1:0]), state encoding for IDLE/FILL/DRAIN.
- One sub-module, fb_fill_ctrl, is natural: row_base computation, col counter, and the 1-cycle lb write pipeline. The top keeps the arbitration mux and the overrun flag.

Test Plan:
- Reset mid-burst: pulse line_req row 5, assert rst_n low at lb_addr=40 -> all outputs 0 and lb_bank=0 asynchronously; after release, no lb_we until the next line_req.
- Single fill: line_req row 3, RAM preloaded with data=addr[7:0] -> reads addr 480..639; 160 lb_we pulses with lb_addr 0..159 and lb_wdata=(480+i)[7:0]; lb_bank=1; fill_busy high exactly 161 cycles.
- CPU vs fill: cpu_valid held with addr 0x0123 data 0xE3, then line_req one cycle later -> one CPU write completes before the line_req cycle; the next write stalls for 161 cycles, then is accepted during DRAIN/IDLE; RAM content checked.
- Collision: cpu_valid and line_req in the same cycle in IDLE -> cpu_ready=0 that cycle; the fill starts; the CPU write lands after the burst.
- Overrun: second line_req (row 7) at col 100 of a row 6 fill -> overrun=1 sticky; lb_bank toggles twice total; new reads start at 1120; the last lb write holds row 7 col 159.
- Last row: line_req row 119 -> reads 19040..19199; the final lb_addr=159.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, pixel field slices and fill-FSM encoding for the VGA
// frame-buffer arbiter slice.
package vga_pkg;

  localparam int H_PIX = 160;
  localparam int V_PIX = 120;
  localparam int AW    = 15;
  localparam int DW    = 8;

  // RRRGGGBB pixel layout
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } fill_state_e;

  // row*160 as row*128 + row*32; rows >= V_PIX are not clamped
  function automatic logic [AW-1:0] row_base_of(input logic [6:0] row);
    return AW'({row, 7'b0}) + AW'({row, 5'b0});
  endfunction

endpackage

// File: rtl/fb_fill_ctrl.sv
// Line-buffer fill sequencer: row base latch, column counter, read issue and
// the one-cycle registered line-buffer write pipeline.
import vga_pkg::*;

module fb_fill_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_req,
  input  logic [6:0]    line_row,
  input  logic [DW-1:0] ram_rdata,
  output fill_state_e   state,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          fill_busy,
  output logic          lb_we,
  output logic          lb_bank,
  output logic [7:0]    lb_addr,
  output logic [DW-1:0] lb_wdata
);

  fill_state_e   state_q, state_d;
  logic [AW-1:0] row_base_q;
  logic [7:0]    col_q;
  logic          last_col;
  logic          lb_we_q;
  logic          lb_bank_q;
  logic [7:0]    lb_addr_q;

  assign last_col = (col_q == 8'(H_PIX - 1));

  // A line_req in any state restarts the burst from column 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (line_req) state_d = ST_FILL;
      ST_FILL: begin
        if (line_req)      state_d = ST_FILL;
        else if (last_col) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = line_req ? ST_FILL : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_base_q <= '0;
      col_q      <= '0;
      lb_bank_q  <= 1'b0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      // the read issued this cycle becomes next cycle's line-buffer write
      lb_we_q   <= (state_q == ST_FILL);
      lb_addr_q <= (state_q == ST_FILL) ? col_q : 8'd0;
      if (line_req) begin
        row_base_q <= row_base_of(line_row);
        col_q      <= '0;
        lb_bank_q  <= ~lb_bank_q;
      end else if (state_q == ST_FILL) begin
        col_q <= col_q + 8'd1;
      end
    end
  end

  assign state     = state_q;
  assign rd_en     = (state_q == ST_FILL);
  assign rd_addr   = rd_en ? (row_base_q + AW'(col_q)) : '0;
  assign fill_busy = (state_q != ST_IDLE);
  assign lb_we     = lb_we_q;
  assign lb_bank   = lb_bank_q;
  assign lb_addr   = lb_addr_q;
  assign lb_wdata  = lb_we_q ? ram_rdata : '0;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: video line fill has absolute priority,
// CPU writes use the cycles the fill leaves free.
import vga_pkg::*;

module vga_fb_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_req,
  input  logic [6:0]    line_row,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          lb_we,
  output logic          lb_bank,
  output logic [7:0]    lb_addr,
  output logic [DW-1:0] lb_wdata,
  output logic          fill_busy,
  output logic          overrun,
  output logic [1:0]    dbg_state
);

  fill_state_e   fill_state;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          overrun_q;

  fb_fill_ctrl u_fill (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_req  (line_req),
    .line_row  (line_row),
    .ram_rdata (ram_rdata),
    .state     (fill_state),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .fill_busy (fill_busy),
    .lb_we     (lb_we),
    .lb_bank   (lb_bank),
    .lb_addr   (lb_addr),
    .lb_wdata  (lb_wdata)
  );

  // CPU handshake: a write transfers in every cycle with cpu_valid && cpu_ready;
  // ready never depends on anything the CPU drives except cpu_valid, and the
  // master must hold addr/data stable while valid is high and ready is low.
  assign cpu_ready = cpu_valid && rst_n && !line_req && (fill_state != ST_FILL);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (rd_en) begin
      ram_en   = 1'b1;
      ram_addr = rd_addr;
    end else if (cpu_ready) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overrun_q <= 1'b0;
    else if (line_req && fill_busy)  overrun_q <= 1'b1;
  end

  assign overrun   = overrun_q;
  assign dbg_state = fill_state;

endmodule
